serial_subtractor: RTL and testbench

- Parametrised multi-cycle subtractor: diff = a - b - borrow_in over WIDTH bits, processed CHUNK bits per clock LSB-first.
- Inter-chunk borrow is held in a register between cycles.
- Valid/ready handshake on both the operand side and the result side.
- Used in the arithmetic datapath where area matters more than latency; successor to the single-bit combinational subtractor.

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 105 ++++++++++
 tb/tb_serial_subtractor.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// master = producer/consumer side, slave = the subtractor itself.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out
  );

  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - borrow_in, CHUNK bits per clock, LSB first, valid/ready on both sides.
// Optional macro SERIAL_SUB_SATURATE_EN clamps a negative result to zero.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK     = WIDTH / CHUNK_SAFE;
  localparam int CW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_bad_params
    $error("serial_subtractor: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
  logic [CHUNK:0]   sub_w;

  // Operands are shifted right each RUN cycle, so the active chunk is always the low slice.
  always_comb begin
    // NOTE: every variable gets its default first so no path leaves one unassigned (no latch).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    sub_w   = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - (CHUNK+1)'(brw_q);

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          brw_d   = bus.borrow_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        diff_d[int'(cnt_q)*CHUNK +: CHUNK] = sub_w[CHUNK-1:0];
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        brw_d = sub_w[CHUNK];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NCHUNK - 1)) begin
          bo_d    = sub_w[CHUNK];
          state_d = S_DONE;
`ifdef SERIAL_SUB_SATURATE_EN
          if (sub_w[CHUNK]) diff_d = '0;
`endif
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the whole datapath is reset, since an aborted operation must leave diff/borrow_out at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, corner sequences, random ops vs. arithmetic model.
// Expectations follow SERIAL_SUB_SATURATE_EN when it is defined for the build.
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_s, b_s;
  logic        bin_s, ordy_s;
  logic [3:0]  iv_s;
  logic [3:0]  ir_v, ov_v, bo_v;
  logic [15:0] dv [4];

  int n_cmp  = 0;
  int n_fail = 0;

  serial_subtractor_if #(.WIDTH(8))  bus0 ();
  serial_subtractor_if #(.WIDTH(16)) bus1 ();
  serial_subtractor_if #(.WIDTH(16)) bus2 ();
  serial_subtractor_if #(.WIDTH(16)) bus3 ();

  serial_subtractor #(.WIDTH(8),  .CHUNK(2))  u_w8c2   (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  serial_subtractor #(.WIDTH(16), .CHUNK(1))  u_w16c1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  serial_subtractor #(.WIDTH(16), .CHUNK(4))  u_w16c4  (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  serial_subtractor #(.WIDTH(16), .CHUNK(16)) u_w16c16 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  assign bus0.in_valid = iv_s[0];  assign bus0.a = a_s[7:0];
  assign bus0.b = b_s[7:0];        assign bus0.borrow_in = bin_s;  assign bus0.out_ready = ordy_s;
  assign bus1.in_valid = iv_s[1];  assign bus1.a = a_s;
  assign bus1.b = b_s;             assign bus1.borrow_in = bin_s;  assign bus1.out_ready = ordy_s;
  assign bus2.in_valid = iv_s[2];  assign bus2.a = a_s;
  assign bus2.b = b_s;             assign bus2.borrow_in = bin_s;  assign bus2.out_ready = ordy_s;
  assign bus3.in_valid = iv_s[3];  assign bus3.a = a_s;
  assign bus3.b = b_s;             assign bus3.borrow_in = bin_s;  assign bus3.out_ready = ordy_s;

  assign ir_v  = {bus3.in_ready,   bus2.in_ready,   bus1.in_ready,   bus0.in_ready};
  assign ov_v  = {bus3.out_valid,  bus2.out_valid,  bus1.out_valid,  bus0.out_valid};
  assign bo_v  = {bus3.borrow_out, bus2.borrow_out, bus1.borrow_out, bus0.borrow_out};
  assign dv[0] = {8'h00, bus0.diff};
  assign dv[1] = bus1.diff;
  assign dv[2] = bus2.diff;
  assign dv[3] = bus3.diff;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int wid(input int s);
    return (s == 0) ? 8 : 16;
  endfunction

  function automatic int nch(input int s);
    case (s)
      0:       return 4;
      1:       return 16;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  // Reference: plain signed arithmetic on the full operands, then reduce modulo 2^w.
  function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b,
                                          input logic bin, input int w);
    longint mask = (longint'(1) << w) - 1;
    longint r    = (longint'(a) & mask) - (longint'(b) & mask) - longint'(bin);
    logic   brw  = (r < 0);
    logic [15:0] d = 16'(r & mask);
`ifdef SERIAL_SUB_SATURATE_EN
    if (brw) d = '0;
`endif
    return {brw, d};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic start_op(input int s, input logic [15:0] a, input logic [15:0] b, input logic bin);
    @(negedge clk);
    check("in_ready_before_accept", 32'(ir_v[s]), 32'd1);
    a_s = a; b_s = b; bin_s = bin;
    iv_s = '0; iv_s[s] = 1'b1;
    @(posedge clk);
    #1;
    iv_s  = '0;
    a_s   = 16'($urandom);
    b_s   = 16'($urandom);
    bin_s = 1'($urandom);
  endtask

  task automatic wait_result(input int s, output int lat, output bit to);
    lat = 0;
    to  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ov_v[s]) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_and_check(input int s, input logic [15:0] a, input logic [15:0] b,
                               input logic bin, input logic [15:0] exp_d, input logic exp_bo);
    int lat;
    bit to;
    ordy_s = 1'b1;
    start_op(s, a, b, bin);
    wait_result(s, lat, to);
    check("result_timeout", 32'(to), 32'd0);
    check("latency", 32'(lat), 32'(nch(s)));
    check("diff", 32'(dv[s]), 32'(exp_d));
    check("borrow_out", 32'(bo_v[s]), 32'(exp_bo));
    check("in_ready_in_done", 32'(ir_v[s]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("out_valid_after_hs", 32'(ov_v[s]), 32'd0);
    check("in_ready_after_hs", 32'(ir_v[s]), 32'd1);
    check("diff_held_after_hs", 32'(dv[s]), 32'(exp_d));
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  initial begin
    vec_t        vecs [7];
    logic [16:0] r;
    logic [15:0] ra, rb;
    logic        rbin;
    int          s, lat, stale;
    bit          to;

    // Wrapped differences; saturated builds zero any entry whose borrow is 1.
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
`ifdef SERIAL_SUB_SATURATE_EN
    foreach (vecs[i]) if (vecs[i].bo) vecs[i].d = 8'h00;
`endif

    rst_n = 1'b0; iv_s = '0; ordy_s = 1'b1;
    a_s = '0; b_s = '0; bin_s = 1'b0;
    #3;
    check("rst_in_ready", 32'(ir_v), 32'hF);
    check("rst_out_valid", 32'(ov_v), 32'h0);
    check("rst_diff", 32'(dv[0]), 32'h0);
    check("rst_borrow_out", 32'(bo_v), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_and_check(0, 16'(vecs[i].a), 16'(vecs[i].b), vecs[i].bin, 16'(vecs[i].d), vecs[i].bo);

    // Backpressure: result held, new operands ignored, exactly one accept after the handshake.
    ordy_s = 1'b0;
    start_op(0, 16'h005A, 16'h003C, 1'b0);
    wait_result(0, lat, to);
    check("bp_timeout", 32'(to), 32'd0);
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_s = 16'($urandom); b_s = 16'($urandom); iv_s[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 32'(ov_v[0]), 32'd1);
      check("bp_diff", 32'(dv[0]), 32'h1E);
      check("bp_in_ready", 32'(ir_v[0]), 32'd0);
    end
    @(negedge clk);
    a_s = 16'h0020; b_s = 16'h0005; bin_s = 1'b0; iv_s[0] = 1'b1; ordy_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_hs_out_valid", 32'(ov_v[0]), 32'd0);
    check("bp_hs_in_ready", 32'(ir_v[0]), 32'd1);
    @(posedge clk);
    #1 iv_s = '0;
    @(negedge clk);
    check("bp_accept_in_ready", 32'(ir_v[0]), 32'd0);
    wait_result(0, lat, to);
    check("bp2_timeout", 32'(to), 32'd0);
    check("bp2_latency", 32'(lat), 32'd4);
    check("bp2_diff", 32'(dv[0]), 32'h1B);
    check("bp2_borrow_out", 32'(bo_v[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp2_hs_in_ready", 32'(ir_v[0]), 32'd1);

    // Asynchronous reset in the second RUN cycle aborts the operation.
    start_op(0, 16'h0033, 16'h0011, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(ov_v[0]), 32'd0);
    check("abort_in_ready", 32'(ir_v[0]), 32'd1);
    check("abort_diff", 32'(dv[0]), 32'h0);
    check("abort_borrow_out", 32'(bo_v[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov_v[0] || !ir_v[0]) stale++;
    end
    check("abort_no_stale_result", 32'(stale), 32'd0);
    run_and_check(0, 16'h005A, 16'h003C, 1'b0, 16'h001E, 1'b0);

    // Width/chunk sweep at 16 bits.
    for (int k = 1; k < 4; k++)
      run_and_check(k, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0);

    // Random operations on all four configurations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      s    = int'($urandom_range(0, 3));
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      if (wid(s) == 8) begin
        ra[15:8] = '0;
        rb[15:8] = '0;
      end
      r = ref_sub(ra, rb, rbin, wid(s));
      run_and_check(s, ra, rb, rbin, r[15:0], r[16]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
